vc_crossbar3_alloc: RTL

Input-buffering and switch-allocation stage that sits directly upstream of the 3×3 crossbar. It queues messages arriving on three val/rdy input ports and arbitrates each output with a round-robin arbiter. It drives the crossbar's `in0..in2` data and `sel0..sel2` selects, plus per-output valid/ready handshakes toward the downstream consumers. Arbitration state is kept separately per security domain, so one domain's traffic never perturbs the other domain's grant order.

---
 rtl/vc_crossbar3_alloc_if.sv | 26 ++
 rtl/vc_crossbar3_alloc.sv | 122 ++++++++++++
 2 files changed

// File: rtl/vc_crossbar3_alloc_if.sv
// Handshake and crossbar-facing bundle for the 3x3 switch allocator.
interface vc_crossbar3_alloc_if #(parameter int p_nbits = 32);
  logic               in0_val, in1_val, in2_val;
  logic               in0_rdy, in1_rdy, in2_rdy;
  logic [p_nbits-1:0] in0_msg, in1_msg, in2_msg;
  logic [1:0]         in0_dest, in1_dest, in2_dest;
  logic [p_nbits-1:0] xbar_in0, xbar_in1, xbar_in2;
  logic [1:0]         sel0, sel1, sel2;
  logic               out0_val, out1_val, out2_val;
  logic               out0_rdy, out1_rdy, out2_rdy;
  logic [2:0]         drop;

  modport master (
    output in0_val, in1_val, in2_val, in0_msg, in1_msg, in2_msg,
           in0_dest, in1_dest, in2_dest, out0_rdy, out1_rdy, out2_rdy,
    input  in0_rdy, in1_rdy, in2_rdy, xbar_in0, xbar_in1, xbar_in2,
           sel0, sel1, sel2, out0_val, out1_val, out2_val, drop
  );

  modport slave (
    input  in0_val, in1_val, in2_val, in0_msg, in1_msg, in2_msg,
           in0_dest, in1_dest, in2_dest, out0_rdy, out1_rdy, out2_rdy,
    output in0_rdy, in1_rdy, in2_rdy, xbar_in0, xbar_in1, xbar_in2,
           sel0, sel1, sel2, out0_val, out1_val, out2_val, drop
  );
endinterface

// File: rtl/vc_crossbar3_alloc.sv
// Input queues plus per-output round-robin switch allocation for a 3x3
// crossbar, with a separate pointer set per security domain.
module vc_in_fifo #(parameter int W = 34) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enq_val,
  output logic         enq_rdy,
  input  logic [W-1:0] enq_data,
  input  logic         deq,
  output logic         nempty,
  output logic [W-1:0] head
);
  logic [W-1:0] mem [2];
  logic         wp, rp;
  logic [1:0]   cnt;
  logic         enq;

  assign enq_rdy = (cnt != 2'd2);
  assign enq     = enq_val && enq_rdy;
  assign nempty  = (cnt != 2'd0);
  assign head    = mem[rp];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (enq) begin
        mem[wp] <= enq_data;
        wp      <= ~wp;
      end
      if (deq) rp <= ~rp;
      cnt <= cnt + {1'b0, enq} - {1'b0, deq};
    end
  end
endmodule

module vc_crossbar3_alloc #(parameter int p_nbits = 32) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cur_sd,
  vc_crossbar3_alloc_if.slave  bus
);
  localparam int W = p_nbits + 2;

  logic [2:0]              in_val, in_rdy, nempty, deq, out_val, out_rdy, drop;
  logic [2:0][W-1:0]       enq_data, head;
  logic [2:0][1:0]         head_dest, sel;
  logic [1:0][2:0][1:0]    ptr;

  assign in_val   = {bus.in2_val, bus.in1_val, bus.in0_val};
  assign out_rdy  = {bus.out2_rdy, bus.out1_rdy, bus.out0_rdy};
  assign enq_data = {{bus.in2_msg, bus.in2_dest},
                     {bus.in1_msg, bus.in1_dest},
                     {bus.in0_msg, bus.in0_dest}};

  for (genvar i = 0; i < 3; i++) begin : g_q
    vc_in_fifo #(.W(W)) u_q (
      .clk      (clk),
      .reset    (reset),
      .enq_val  (in_val[i]),
      .enq_rdy  (in_rdy[i]),
      .enq_data (enq_data[i]),
      .deq      (deq[i]),
      .nempty   (nempty[i]),
      .head     (head[i])
    );
    assign head_dest[i] = head[i][1:0];
    assign drop[i]      = nempty[i] && (head_dest[i] == 2'd3);
  end

  // Scan ptr, ptr+1, ptr+2 (mod 3) under the active domain's pointer.
  always_comb begin
    logic [2:0] idx;
    idx     = '0;
    out_val = '0;
    sel     = '0;
    for (int j = 0; j < 3; j++) begin
      for (int k = 0; k < 3; k++) begin
        idx = {1'b0, ptr[cur_sd][j]} + 3'(k);
        if (idx >= 3'd3) idx = idx - 3'd3;
        if (!out_val[j] && nempty[idx[1:0]] && head_dest[idx[1:0]] == 2'(j)) begin
          out_val[j] = 1'b1;
          sel[j]     = idx[1:0];
        end
      end
    end
  end

  always_comb begin
    deq = drop;
    for (int j = 0; j < 3; j++)
      if (out_val[j] && out_rdy[j]) deq[sel[j]] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else begin
      for (int j = 0; j < 3; j++)
        if (out_val[j] && out_rdy[j])
          ptr[cur_sd][j] <= (sel[j] == 2'd2) ? 2'd0 : sel[j] + 2'd1;
    end
  end

  assign bus.in0_rdy  = in_rdy[0];
  assign bus.in1_rdy  = in_rdy[1];
  assign bus.in2_rdy  = in_rdy[2];
  assign bus.xbar_in0 = head[0][W-1:2];
  assign bus.xbar_in1 = head[1][W-1:2];
  assign bus.xbar_in2 = head[2][W-1:2];
  assign bus.sel0     = sel[0];
  assign bus.sel1     = sel[1];
  assign bus.sel2     = sel[2];
  assign bus.out0_val = out_val[0];
  assign bus.out1_val = out_val[1];
  assign bus.out2_val = out_val[2];
  assign bus.drop     = drop;
endmodule
